// File: rtl/sram_rw_arb.sv
// -----------------------------------------------------------------------------
// sram_rw_arb
// Arbitrates a write request stream and a read request stream onto a single-port
// SRAM array. Writes win by default; a read response is held in a one-entry
// output register until the consumer accepts it.
//
// Optional feature (compile-time macro SRAM_RW_ARB_STARVE_GUARD_EN):
//   a 2-bit starvation counter forces one read through after three cycles in
//   which an eligible read lost to a write.
// -----------------------------------------------------------------------------
module sram_rw_arb #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 261,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    // write request
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_mask,
    // read request
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [ADDR_W-1:0] r_addr,
    // read response
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    // single-port array
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    // Addresses are forwarded untouched, so entries beyond DEPTH are the array's
    // concern; only reject a configuration whose DEPTH cannot even be addressed.
    if (DEPTH > (1 << ADDR_W)) begin : g_depth_check
        $error("sram_rw_arb: DEPTH does not fit in ADDR_W address bits");
    end

    logic              rd_inflight_q, rd_inflight_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q;
    logic              read_eligible;
    logic              force_read;
    logic              w_fire;
    logic              r_fire;

    // A read may issue only when the response register will be free by the
    // time its data arrives: nothing in flight and no unaccepted response.
    always_comb begin
        read_eligible = !rd_inflight_q && (!resp_valid_q || resp_ready);
    end

`ifdef SRAM_RW_ARB_STARVE_GUARD_EN
    logic [1:0] starve_cnt_q, starve_cnt_d;

    // Saturated counter: the read takes the slot away from writes.
    always_comb begin
        force_read = (starve_cnt_q == 2'd3) && read_eligible;
    end

    // Count cycles where an eligible read lost to a write; a read fire clears it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (r_fire) begin
            starve_cnt_d = 2'd0;
        end else if (r_valid && read_eligible && w_valid && (starve_cnt_q != 2'd3)) begin
            starve_cnt_d = starve_cnt_q + 2'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= 2'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Strict write priority: reads never pre-empt writes.
    always_comb begin
        force_read = 1'b0;
    end
`endif

    // Handshake readies. reset_n gates them directly so that nothing is
    // accepted while reset is held, and requests are taken on the very
    // first edge after release.
    always_comb begin
        w_ready = reset_n && !force_read;
        r_ready = reset_n && read_eligible && (force_read || !w_valid);
        w_fire  = w_valid && w_ready;
        r_fire  = r_valid && r_ready;
    end

    // Array command: the two fires are mutually exclusive by construction.
    always_comb begin
        sram_en    = w_fire || r_fire;
        sram_wmode = w_fire;
        sram_addr  = w_fire ? w_addr : r_addr;
        sram_wmask = w_fire && w_mask;
        sram_wdata = w_data;
    end

    // Response tracking: a capture always sets valid (it can coincide with the
    // accept of the previous response); otherwise an accept clears it.
    always_comb begin
        rd_inflight_d = r_fire;
        resp_valid_d  = resp_valid_q;
        if (rd_inflight_q) begin
            resp_valid_d = 1'b1;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // Control state; a reset drops any read in flight so it never responds.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_inflight_q <= 1'b0;
            resp_valid_q  <= 1'b0;
        end else begin
            rd_inflight_q <= rd_inflight_d;
            resp_valid_q  <= resp_valid_d;
        end
    end

    // Capture array read data the cycle after the read enable.
    // NOTE: the data register has no reset; resp_valid qualifies it, and
    // leaving wide datapath flops unreset keeps the reset tree small.
    always_ff @(posedge clock) begin
        if (rd_inflight_q) begin
            resp_data_q <= sram_rdata;
        end
    end

    // Output assignments.
    always_comb begin
        resp_valid = resp_valid_q;
        resp_data  = resp_data_q;
    end

endmodule

// File: doc/sram_rw_arb.md
SRAM_RW_ARB -- requirements
Module: sram_rw_arb

Interface
REQ-001 SHALL have parameters: ADDR_W, default 2, array address width; DATA_W, default 261, array data width; DEPTH, default 4, array entries.
REQ-002 SHALL have ports:
- clock  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- w_valid, w_ready  in/out  1/1  write request handshake.
- w_addr  in  ADDR_W  write entry.
- w_data  in  DATA_W  write data.
- w_mask  in  1  write enable mask.
- r_valid, r_ready  in/out  1/1  read request handshake.
- r_addr  in  ADDR_W  read entry.
- resp_valid, resp_ready  out/in  1/1  read response handshake.
- resp_data  out  DATA_W  read response data.
- sram_en, sram_wmode  out  1/1  single-port array enable and write mode.
- sram_addr  out  ADDR_W  array address.
- sram_wmask  out  1  array write mask.
- sram_wdata  out  DATA_W  array write data.
- sram_rdata  in  DATA_W  array read data; valid the cycle after a read enable.

Function
REQ-003 SHALL issue at most one array operation per cycle; sram_en = write fire OR read fire.
REQ-004 Write fire (w_valid && w_ready) SHALL drive sram_wmode=1 and pass w_addr/w_mask/w_data to sram_addr/sram_wmask/sram_wdata in the same cycle.
REQ-005 Read fire (r_valid && r_ready) SHALL drive sram_wmode=0 and sram_addr=r_addr.
REQ-006 Read eligible SHALL be: no read in flight AND (resp_valid==0 OR resp_ready==1).
REQ-007 Default arbitration SHALL give writes priority: w_ready=1; r_ready = read eligible AND NOT w_valid.
REQ-008 A read fired in cycle N SHALL set rd_inflight during N+1; sram_rdata SHALL be captured into resp_data at the end of N+1; resp_valid SHALL be asserted from N+2.
REQ-009 resp_valid/resp_data SHALL hold stable until resp_ready; resp_valid SHALL clear on accept unless a capture occurs in the same cycle.
REQ-010 A write in cycle N+1 to the in-flight read address SHALL NOT alter the captured data; the response returns pre-write contents.
REQ-011 Maximum read throughput SHALL be one read every 2 cycles with resp_ready held high; writes SHALL be accepted back-to-back.
REQ-012 Address wrap-around SHALL NOT be applied; addresses >= DEPTH are passed unchanged to the array.

Reset
REQ-013 While reset_n is low: resp_valid=0, rd_inflight=0, starve_cnt=0, w_ready=0, r_ready=0, sram_en=0; resp_data holds no defined value.
REQ-014 Reset asserted with a read in flight SHALL drop that read; no response SHALL be produced after release.
REQ-015 First request SHALL be accepted in the first clock edge after reset_n deasserts.

Configuration
REQ-016 Macro SRAM_RW_ARB_STARVE_GUARD_EN defined: a 2-bit starve_cnt SHALL increment in each cycle where r_valid, read eligible and w_valid all hold, and clear on read fire. At starve_cnt==3, r_ready=1 if read eligible, and w_ready=0 for that cycle.
REQ-017 Macro undefined: starve_cnt SHALL be absent, and strict write priority (REQ-007) SHALL apply.

Verification
REQ-018 Write addr 1 data 0x1AB, then read addr 1 with resp_ready=1 -> resp_valid exactly 2 cycles after read fire, resp_data=0x1AB.
REQ-019 Hold resp_ready=0 after one read -> resp_valid held and data stable; r_ready=0 until resp_ready=1; a read fired in the accept cycle responds 2 cycles later.
REQ-020 Read addr 2 (holds 0x5), then write 0x7 to addr 2 in the next cycle -> resp_data=0x5; a following read returns 0x7.
REQ-021 w_valid and r_valid held high for 8 cycles -> without the macro, 8 writes and 0 reads; with SRAM_RW_ARB_STARVE_GUARD_EN, a read fires in cycle 4 and w_ready=0 in that cycle.
REQ-022 Drop reset_n in the cycle after a read fire -> after release, resp_valid stays 0 and sram_en=0 with no request inputs active.
